// File: rtl/mem_access_reg.sv
// MAR/MDR register pair between the CPU datapath and data memory.
// Latches one access, runs a req/ack bus cycle with timeout, holds the result.
module mem_access_reg #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic              wr;
  logic              err;
  logic [CW-1:0]     cnt;
  logic              tmo;

  assign tmo = (cnt == CW'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mar   <= '0;
      mdr   <= '0;
      wr    <= 1'b0;
      err   <= 1'b0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cpu_valid) begin
            mar   <= cpu_addr;
            wr    <= cpu_write;
            mdr   <= cpu_write ? cpu_wdata : '0;
            cnt   <= CW'(1);
            err   <= 1'b0;
            state <= BUSY;
          end
        end
        BUSY: begin
          // ack beats timeout when both land on the same edge
          if (mem_ack) begin
            if (!wr) mdr <= mem_rdata;
            state <= RESP;
          end else if (tmo) begin
            err   <= 1'b1;
            mdr   <= '0;
            state <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cpu_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = mdr;
  assign resp_err   = err;
  assign mem_req    = (state == BUSY);
  assign mem_write  = (state == BUSY) & wr;
  assign mem_addr   = mar;
  assign mem_wdata  = mdr;

endmodule

// File: tb/tb_mem_access_reg.sv
// Directed and randomized checks of mem_access_reg against a
// transaction-level model of latency, timeout and result data.
module tb_mem_access_reg;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_valid = 1'b0;
  logic        cpu_ready;
  logic        cpu_write = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int vecs = 0;
  int errs = 0;

  mem_access_reg #(
    .DATA_W(32),
    .ADDR_W(16),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cpu_valid(cpu_valid),
    .cpu_ready(cpu_ready),
    .cpu_write(cpu_write),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_req(mem_req),
    .mem_write(mem_write),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".cpu_ready"}, cpu_ready, 1);
    chk({tag, ".resp_valid"}, resp_valid, 0);
    chk({tag, ".resp_err"}, resp_err, 0);
    chk({tag, ".resp_rdata"}, resp_rdata, 0);
    chk({tag, ".mem_req"}, mem_req, 0);
    chk({tag, ".mem_write"}, mem_write, 0);
    chk({tag, ".mem_addr"}, mem_addr, 0);
    chk({tag, ".mem_wdata"}, mem_wdata, 0);
  endtask

  // k = BUSY cycle carrying the ack (k > TO means no ack at all);
  // hold = number of RESP cycles with resp_ready low.
  task automatic txn(input bit w, input logic [15:0] a,
                     input logic [31:0] wd, input int k,
                     input logic [31:0] rd, input int hold);
    bit          to;
    logic [31:0] exp_d;
    int          busy_cycles;
    to = (k > TO);
    exp_d = to ? 32'h0 : (w ? wd : rd);
    busy_cycles = 0;
    @(negedge clk);
    chk("idle.cpu_ready", cpu_ready, 1);
    chk("idle.mem_req", mem_req, 0);
    cpu_valid = 1'b1;
    cpu_write = w;
    cpu_addr  = a;
    cpu_wdata = wd;
    @(posedge clk);
    #1;
    cpu_valid = 1'b0;
    cpu_write = ~w;
    cpu_addr  = 16'($urandom);
    cpu_wdata = $urandom;
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      busy_cycles++;
      chk("busy.mem_req", mem_req, 1);
      chk("busy.mem_addr", mem_addr, a);
      chk("busy.mem_write", mem_write, w);
      chk("busy.mem_wdata", mem_wdata, w ? wd : 32'h0);
      chk("busy.cpu_ready", cpu_ready, 0);
      chk("busy.resp_valid", resp_valid, 0);
      if (c == k) begin
        mem_ack = 1'b1;
        mem_rdata = rd;
      end else begin
        mem_rdata = $urandom;
      end
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (c == k) break;
    end
    chk("busy.cycles", busy_cycles, to ? TO : k);
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      chk("resp.valid", resp_valid, 1);
      chk("resp.rdata", resp_rdata, exp_d);
      chk("resp.err", resp_err, to);
      chk("resp.mem_req", mem_req, 0);
      chk("resp.mem_write", mem_write, 0);
      chk("resp.cpu_ready", cpu_ready, 0);
      if (h == hold) begin
        resp_ready = 1'b1;
        cpu_valid  = 1'b0;
      end else begin
        resp_ready = 1'b0;
        cpu_valid  = 1'b1;
        cpu_addr   = 16'($urandom);
        mem_ack    = 1'($urandom);
        mem_rdata  = $urandom;
      end
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      mem_ack    = 1'b0;
    end
  endtask

  initial begin
    #1;
    chk_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;

    // reset while a load is stalled in BUSY
    @(negedge clk);
    cpu_valid = 1'b1;
    cpu_write = 1'b0;
    cpu_addr  = 16'h0040;
    @(posedge clk);
    #1;
    cpu_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("midbusy.mem_req", mem_req, 1);
    chk("midbusy.mem_addr", mem_addr, 16'h0040);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    txn(1'b0, 16'h1234, 32'h0, 1, 32'hDEADBEEF, 0);
    txn(1'b1, 16'h0004, 32'hACEDCAFE, 3, 32'h0, 0);
    txn(1'b0, 16'h0100, 32'h0, TO + 1, 32'h0, 0);
    txn(1'b0, 16'h0200, 32'h0, TO, 32'h00C0FFEE, 0);
    txn(1'b1, 16'h0300, 32'h12345678, TO + 1, 32'h0, 1);
    txn(1'b0, 16'h0404, 32'h0, 2, 32'h55AA55AA, 5);
    txn(1'b1, 16'h0808, 32'h0BADF00D, 1, 32'hFFFFFFFF, 0);

    for (int i = 0; i < 40; i++) begin
      txn(1'($urandom), 16'($urandom), $urandom,
          int'($urandom_range(1, TO + 1)), $urandom,
          int'($urandom_range(0, 3)));
    end

    @(negedge clk);
    chk("end.cpu_ready", cpu_ready, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
